// File: rtl/cpu_sequencer_if.sv
// Bus and handshake bundle between the instruction sequencer and its datapath.
//
// Handshake semantics:
//   Input port : the device raises in_valid and holds it with its byte until it
//                sees in_ack. in_ack is high only in the cycle the byte is moved
//                onto the bus. Together with bus_en, it is the transfer strobe.
//   Output port: the sequencer raises out_valid and holds it steady until
//                out_ready is seen. The transfer (bus_en) happens in the cycle
//                where out_valid && out_ready, and out_valid drops afterwards.
interface cpu_sequencer_if;
  logic [7:0] instr;
  logic [7:0] jmp_target;
  logic       cond_true;
  logic       in_valid;
  logic       out_ready;
  logic [7:0] pc;
  logic [7:0] ir;
  logic [2:0] src_sel;
  logic [2:0] dst_sel;
  logic       bus_en;
  logic       imm_en;
  logic       alu_en;
  logic       in_ack;
  logic       out_valid;
  logic       busy;
  logic       fault;

  modport master (
    input  instr, jmp_target, cond_true, in_valid, out_ready,
    output pc, ir, src_sel, dst_sel, bus_en, imm_en, alu_en,
           in_ack, out_valid, busy, fault
  );

  modport slave (
    output instr, jmp_target, cond_true, in_valid, out_ready,
    input  pc, ir, src_sel, dst_sel, bus_en, imm_en, alu_en,
           in_ack, out_valid, busy, fault
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Instruction sequencer for a small 8-bit CPU.
// The sequencer fetches one byte per instruction, decodes it, and issues
// one-cycle strobes to the datapath. It also runs the byte-wide I/O handshakes.
// The EXEC strobes are decoded from instr during FETCH, so they come out of
// flops. The I/O transfer strobes are combinational with the device's valid or
// ready, so the bus transfer lands in the same cycle as the handshake.
module cpu_sequencer (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            step,
  cpu_sequencer_if.master sbus,
  output logic [2:0]      state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_FETCH    = 3'd1,
    S_EXEC     = 3'd2,
    S_WAIT_IN  = 3'd3,
    S_WAIT_OUT = 3'd4,
    S_FAULT    = 3'd5
  } state_t;

  localparam logic [2:0] SEL_IO  = 3'd6;
  localparam logic [2:0] SEL_BAD = 3'd7;

  state_t     state;
  logic [7:0] pc_q;
  logic [7:0] ir_q;
  logic [2:0] src_q;
  logic [2:0] dst_q;
  logic       bus_q;
  logic       imm_q;
  logic       alu_q;
  logic       out_valid_q;
  logic       busy_q;
  logic       fault_q;

  logic [1:0] op;
  logic [2:0] ir_src;
  logic [2:0] ir_dst;
  logic [7:0] pc_inc;
  state_t     done_state;
  logic       fetch_plain_copy;
  logic       in_xfer;
  logic       out_xfer;

  assign op      = ir_q[7:6];
  assign ir_src  = ir_q[5:3];
  assign ir_dst  = ir_q[2:0];
  // pc wraps naturally at 8 bits
  assign pc_inc  = pc_q + 8'd1;
  // where an instruction goes when it completes: keep running or park
  assign done_state = run ? S_FETCH : S_IDLE;

  // register-to-register copy: both fields name r0-r5
  assign fetch_plain_copy = (sbus.instr[7:6] == 2'b10) &&
                            (sbus.instr[5:3] < SEL_IO) &&
                            (sbus.instr[2:0] < SEL_IO);

  assign in_xfer  = (state == S_WAIT_IN) && sbus.in_valid;
  assign out_xfer = out_valid_q && sbus.out_ready;

  // Sequencer FSM: state, program counter, latched instruction and registered strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= S_IDLE;
      pc_q        <= 8'h00;
      ir_q        <= 8'h00;
      src_q       <= 3'd0;
      dst_q       <= 3'd0;
      bus_q       <= 1'b0;
      imm_q       <= 1'b0;
      alu_q       <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      // EXEC strobes last exactly one cycle
      bus_q <= 1'b0;
      imm_q <= 1'b0;
      alu_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run || step) begin
            state  <= S_FETCH;
            busy_q <= 1'b1;
          end
        end
        S_FETCH: begin
          ir_q  <= sbus.instr;
          src_q <= sbus.instr[5:3];
          dst_q <= sbus.instr[2:0];
          imm_q <= (sbus.instr[7:6] == 2'b00);
          alu_q <= (sbus.instr[7:6] == 2'b01);
          bus_q <= fetch_plain_copy;
          state <= S_EXEC;
        end
        S_EXEC: begin
          case (op)
            2'b10: begin
              if (ir_src == SEL_BAD || ir_dst == SEL_BAD) begin
                state   <= S_FAULT;
                busy_q  <= 1'b0;
                fault_q <= 1'b1;
              end else if (ir_src == SEL_IO) begin
                state <= S_WAIT_IN;
              end else if (ir_dst == SEL_IO) begin
                state       <= S_WAIT_OUT;
                out_valid_q <= 1'b1;
              end else begin
                pc_q   <= pc_inc;
                state  <= done_state;
                busy_q <= run;
              end
            end
            2'b11: begin
              pc_q   <= sbus.cond_true ? sbus.jmp_target : pc_inc;
              state  <= done_state;
              busy_q <= run;
            end
            default: begin
              pc_q   <= pc_inc;
              state  <= done_state;
              busy_q <= run;
            end
          endcase
        end
        S_WAIT_IN: begin
          if (sbus.in_valid) begin
            if (ir_dst == SEL_IO) begin
              // port-to-port copy: the output phase follows, pc waits for it
              state       <= S_WAIT_OUT;
              out_valid_q <= 1'b1;
            end else begin
              pc_q   <= pc_inc;
              state  <= done_state;
              busy_q <= run;
            end
          end
        end
        S_WAIT_OUT: begin
          if (sbus.out_ready) begin
            out_valid_q <= 1'b0;
            pc_q        <= pc_inc;
            state       <= done_state;
            busy_q      <= run;
          end
        end
        S_FAULT: begin
          // only reset leaves FAULT
        end
        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign sbus.pc        = pc_q;
  assign sbus.ir        = ir_q;
  assign sbus.src_sel   = src_q;
  assign sbus.dst_sel   = dst_q;
  assign sbus.imm_en    = imm_q;
  assign sbus.alu_en    = alu_q;
  assign sbus.bus_en    = bus_q | in_xfer | out_xfer;
  assign sbus.in_ack    = in_xfer;
  assign sbus.out_valid = out_valid_q;
  assign sbus.busy      = busy_q;
  assign sbus.fault     = fault_q;
  assign state_dbg      = state;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Testbench for cpu_sequencer.
// The first part is a directed, cycle-by-cycle walk through the timing cases.
// After that, random programs run free and single-stepped. In those phases an
// instruction-level reference model pushes the expected event stream, and a
// monitor compares it against what the DUT presents.
module tb_cpu_sequencer;

  localparam int W = 17;  // event: kind[3] src[3] dst[3] pc[8]
  localparam logic [2:0] K_NONE  = 3'd0;
  localparam logic [2:0] K_FETCH = 3'd1;
  localparam logic [2:0] K_IMM   = 3'd2;
  localparam logic [2:0] K_CALC  = 3'd3;
  localparam logic [2:0] K_COPY  = 3'd4;
  localparam logic [2:0] K_IN    = 3'd5;
  localparam logic [2:0] K_OUT   = 3'd6;
  localparam logic [2:0] K_BAD   = 3'd7;
  localparam logic [2:0] FETCH_CODE = 3'd1;

  // ---------------- clock / reset / DUT ----------------
  logic       clk;
  logic       rst;
  logic       run;
  logic       step;
  logic [2:0] state_dbg;

  cpu_sequencer_if sif();

  cpu_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .step      (step),
    .sbus      (sif),
    .state_dbg (state_dbg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- environment (program memory, r0, I/O devices) ----------------
  logic [7:0] mem [256];
  logic [7:0] r0_env;
  logic       rand_io, force_cond;
  logic       dir_in_valid, dir_out_ready, rnd_in_valid, rnd_out_ready, dir_cond;
  logic [7:0] dir_jt;
  logic       sb_on;

  assign sif.instr      = mem[sif.pc];
  assign sif.in_valid   = rand_io ? rnd_in_valid : dir_in_valid;
  assign sif.out_ready  = rand_io ? rnd_out_ready : dir_out_ready;
  assign sif.cond_true  = force_cond ? dir_cond : sif.ir[0];
  assign sif.jmp_target = force_cond ? dir_jt : r0_env;

  // r0 in the datapath: written by imm instructions
  always @(posedge clk or negedge rst) begin
    if (!rst) r0_env <= 8'h00;
    else if (sif.imm_en) r0_env <= {2'b00, sif.ir[5:0]};
  end

  initial begin
    rnd_in_valid  = 1'b0;
    rnd_out_ready = 1'b0;
    forever begin
      @(negedge clk);
      rnd_in_valid  = ($urandom_range(0, 1) == 1);
      rnd_out_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [W-1:0] exp_q[$];
  logic [7:0]   m_pc, m_r0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] ev(input logic [2:0] k, input logic [2:0] s,
                                      input logic [2:0] d, input logic [7:0] p);
    return {k, s, d, p};
  endfunction

  // Instruction-level reference: run one instruction from m_pc and list what the bus must show
  task automatic model_one();
    logic [7:0] ins;
    logic [2:0] s, d;
    ins = mem[m_pc];
    s = ins[5:3];
    d = ins[2:0];
    exp_q.push_back(ev(K_FETCH, 3'd0, 3'd0, m_pc));
    case (ins[7:6])
      2'b00: begin
        exp_q.push_back(ev(K_IMM, 3'd0, 3'd0, m_pc));
        m_r0 = {2'b00, ins[5:0]};
        m_pc = m_pc + 8'd1;
      end
      2'b01: begin
        exp_q.push_back(ev(K_CALC, 3'd0, 3'd0, m_pc));
        m_pc = m_pc + 8'd1;
      end
      2'b10: begin
        if (s == 3'd6) exp_q.push_back(ev(K_IN, s, d, m_pc));
        if (d == 3'd6) exp_q.push_back(ev(K_OUT, s, d, m_pc));
        if (s != 3'd6 && d != 3'd6) exp_q.push_back(ev(K_COPY, s, d, m_pc));
        m_pc = m_pc + 8'd1;
      end
      default: m_pc = ins[0] ? m_r0 : m_pc + 8'd1;
    endcase
  endtask

  task automatic gen_program();
    for (int a = 0; a < 256; a++) begin
      logic [1:0] op;
      logic [2:0] s, d;
      op = 2'($urandom_range(0, 3));
      s  = 3'($urandom_range(0, 6));
      d  = 3'($urandom_range(0, 6));
      if (op == 2'b10) mem[a] = {op, s, d};
      else mem[a] = {op, 6'($urandom_range(0, 63))};
    end
  endtask

  // Monitor: classifies each cycle's outputs into an event and checks it against exp_q
  initial begin
    logic [2:0] k, s, d;
    logic [2:0] strobes;
    forever begin
      @(negedge clk);
      #2;
      if (sb_on) begin
        k = K_NONE;
        s = 3'd0;
        d = 3'd0;
        strobes = {sif.imm_en, sif.alu_en, sif.bus_en};
        if (state_dbg == FETCH_CODE) k = (strobes == 3'b000 && !sif.in_ack) ? K_FETCH : K_BAD;
        else if (strobes == 3'b100 && !sif.in_ack) k = K_IMM;
        else if (strobes == 3'b010 && !sif.in_ack) k = K_CALC;
        else if (strobes == 3'b001) begin
          s = sif.src_sel;
          d = sif.dst_sel;
          if (sif.in_ack) k = sif.out_valid ? K_BAD : K_IN;
          else if (sif.out_valid) k = K_OUT;
          else k = K_COPY;
        end else if (strobes != 3'b000 || sif.in_ack) k = K_BAD;
        if (k != K_NONE) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL sb_unexpected: got event %0h expected none", ev(k, s, d, sif.pc));
          end else begin
            chk("sb_event", 32'(ev(k, s, d, sif.pc)), 32'(exp_q.pop_front()));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_idle(input string name);
    int c;
    c = 0;
    while (sif.busy && c < 300) begin
      @(negedge clk);
      c++;
    end
    chk(name, 32'(sif.busy), 32'h0);
  endtask

  task automatic reset_pulse();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0; run = 1'b0; step = 1'b0; sb_on = 1'b0;
    rand_io = 1'b0; force_cond = 1'b0; dir_cond = 1'b0; dir_jt = 8'h00;
    dir_in_valid = 1'b0; dir_out_ready = 1'b0;
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pc", 32'(sif.pc), 32'h0);
    chk("rst_ir", 32'(sif.ir), 32'h0);
    chk("rst_outs", 32'({sif.bus_en, sif.imm_en, sif.alu_en, sif.in_ack,
                         sif.out_valid, sif.busy, sif.fault}), 32'h0);

    // free run: imm 5, copy r0->r1, cond-jump to 0xFF, calc wraps pc to 0x00
    mem[0] = 8'h05; mem[1] = 8'h81; mem[2] = 8'hC0; mem[255] = 8'h40;
    force_cond = 1'b1; dir_cond = 1'b1; dir_jt = 8'hFF;
    rst = 1'b1; run = 1'b1;
    @(negedge clk); chk("c1_pc", 32'(sif.pc), 32'h0);
    @(negedge clk); chk("c2_pc", 32'(sif.pc), 32'h0);
    chk("c2_strobes", 32'({sif.imm_en, sif.alu_en, sif.bus_en}), 32'b100);
    chk("c2_ir", 32'(sif.ir), 32'h05);
    @(negedge clk); chk("c3_pc", 32'(sif.pc), 32'h1);
    @(negedge clk); chk("c4_pc", 32'(sif.pc), 32'h1);
    chk("c4_strobes", 32'({sif.imm_en, sif.alu_en, sif.bus_en}), 32'b001);
    chk("c4_sel", 32'({sif.src_sel, sif.dst_sel}), 32'({3'd0, 3'd1}));
    @(negedge clk); chk("c5_pc", 32'(sif.pc), 32'h2);
    @(negedge clk); chk("cond_no_strobe", 32'({sif.imm_en, sif.alu_en, sif.bus_en}), 32'b000);
    @(negedge clk); chk("jump_pc", 32'(sif.pc), 32'hFF);
    @(negedge clk); chk("calc_alu", 32'(sif.alu_en), 32'h1);
    @(negedge clk); chk("wrap_pc", 32'(sif.pc), 32'h0);
    chk("calc_alu_once", 32'(sif.alu_en), 32'h0);
    run = 1'b0;  // falls during FETCH: the imm finishes, then IDLE
    @(negedge clk);
    @(negedge clk); chk("runfall_busy", 32'(sif.busy), 32'h0);
    chk("runfall_pc", 32'(sif.pc), 32'h1);

    // step through a not-taken cond; a second step during EXEC is ignored
    mem[1] = 8'hC0; dir_cond = 1'b0; step = 1'b1;
    @(negedge clk); step = 1'b0;
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
    chk("step_pc", 32'(sif.pc), 32'h2);
    chk("step_busy", 32'(sif.busy), 32'h0);
    @(negedge clk); chk("step_ignored_busy", 32'(sif.busy), 32'h0);
    chk("step_ignored_pc", 32'(sif.pc), 32'h2);

    // input copy with in_valid held low for 5 cycles
    mem[2] = 8'hB0; dir_in_valid = 1'b0; step = 1'b1;
    @(negedge clk); step = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("win_hold", 32'({sif.bus_en, sif.in_ack, sif.busy}), 32'b001);
    end
    dir_in_valid = 1'b1;
    #1 chk("win_xfer", 32'({sif.bus_en, sif.in_ack}), 32'b11);
    chk("win_sel", 32'({sif.src_sel, sif.dst_sel}), 32'({3'd6, 3'd0}));
    @(negedge clk);
    chk("win_done", 32'({sif.bus_en, sif.in_ack, sif.busy}), 32'b000);
    chk("win_pc", 32'(sif.pc), 32'h3);
    dir_in_valid = 1'b0;

    // illegal select code 7 faults and freezes pc until reset
    mem[3] = 8'hBF; step = 1'b1;
    @(negedge clk); step = 1'b0;
    @(negedge clk);
    @(negedge clk); chk("fault_set", 32'({sif.fault, sif.busy}), 32'b10);
    chk("fault_pc", 32'(sif.pc), 32'h3);
    run = 1'b1;
    repeat (3) @(negedge clk);
    chk("fault_stuck", 32'({sif.fault, sif.busy}), 32'b10);
    chk("fault_pc_frozen", 32'(sif.pc), 32'h3);
    #2 rst = 1'b0;
    #1 chk("fault_rst_async", 32'({sif.fault, sif.busy}), 32'b00);
    chk("fault_rst_pc", 32'(sif.pc), 32'h0);
    run = 1'b0;
    @(negedge clk); rst = 1'b1;

    // output copy r0->port: out_valid holds until out_ready, then one transfer
    mem[0] = 8'h86; mem[1] = 8'h86; dir_out_ready = 1'b0; step = 1'b1;
    @(negedge clk); step = 1'b0;
    @(negedge clk);
    @(negedge clk); chk("wout_valid", 32'({sif.out_valid, sif.bus_en}), 32'b10);
    @(negedge clk); chk("wout_stable", 32'({sif.out_valid, sif.bus_en}), 32'b10);
    dir_out_ready = 1'b1;
    #1 chk("wout_xfer", 32'({sif.out_valid, sif.bus_en}), 32'b11);
    @(negedge clk); chk("wout_done", 32'({sif.out_valid, sif.bus_en, sif.busy}), 32'b000);
    chk("wout_pc", 32'(sif.pc), 32'h1);
    dir_out_ready = 1'b0; step = 1'b1;
    @(negedge clk); step = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #3 rst = 1'b0;
    #1 chk("wout_rst_async", 32'({sif.out_valid, sif.busy}), 32'b00);
    @(negedge clk); rst = 1'b1;

    // random free-run program against the reference model
    force_cond = 1'b0;
    rand_io = 1'b1;
    reset_pulse();
    gen_program();
    m_pc = 8'h00; m_r0 = 8'h00;
    for (int i = 0; i < 150; i++) model_one();
    exp_q.push_back(ev(K_FETCH, 3'd0, 3'd0, m_pc));
    sb_on = 1'b1; run = 1'b1;
    begin
      int c;
      c = 0;
      while (exp_q.size() != 0 && c < 5000) begin
        @(negedge clk);
        #4;
        c++;
      end
    end
    chk("run_drain", 32'(exp_q.size()), 32'h0);
    sb_on = 1'b0; run = 1'b0;
    exp_q.delete();
    wait_idle("run_idle");

    // random single-step program, with stray steps during EXEC
    reset_pulse();
    gen_program();
    m_pc = 8'h00; m_r0 = 8'h00;
    sb_on = 1'b1;
    for (int i = 0; i < 40; i++) begin
      model_one();
      step = 1'b1;
      @(negedge clk); step = 1'b0;
      @(negedge clk); step = ($urandom_range(0, 1) == 1);
      @(negedge clk); step = 1'b0;
      wait_idle("step_idle");
      #3 chk("step_drain", 32'(exp_q.size()), 32'h0);
      exp_q.delete();
    end
    sb_on = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
